// File: rtl/concatena_campos_if.sv
// rtl/concatena_campos_if.sv - field input and packed word output handshake bundle
interface concatena_campos_if #(
    parameter int CAMPO   = 4,
    parameter int NCAMPOS = 3
) ();
    localparam int W = CAMPO * NCAMPOS;

    logic             entrada_valida;
    logic [CAMPO-1:0] entrada;
    logic             entrada_pronta;
    logic [W-1:0]     Saida;
    logic             saida_valida;
    logic             saida_pronta;

    modport master (
        output entrada_valida,
        output entrada,
        input  entrada_pronta,
        input  Saida,
        input  saida_valida,
        output saida_pronta
    );

    modport slave (
        input  entrada_valida,
        input  entrada,
        output entrada_pronta,
        output Saida,
        output saida_valida,
        input  saida_pronta
    );
endinterface

// File: rtl/concatena_campos.sv
// rtl/concatena_campos.sv - packs NCAMPOS fields of CAMPO bits into one word under valid/ready
module concatena_campos #(
    parameter int CAMPO   = 4,
    parameter int NCAMPOS = 3,
    parameter int ORDEM   = 0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             limpa,
    concatena_campos_if.slave                bus,
    output logic [$clog2(NCAMPOS+1)-1:0]     contagem
);
    localparam int W  = CAMPO * NCAMPOS;
    localparam int CW = $clog2(NCAMPOS + 1);

    typedef enum logic {ACUMULA = 1'b0, CHEIO = 1'b1} estado_t;

    estado_t       estado;
    logic [W-1:0]  acc;
    logic [W-1:0]  base;
    logic [W-1:0]  campo_ext;
    logic [W-1:0]  nova;
    logic [CW-1:0] cont;
    logic [CW-1:0] cont_nova;
    logic          valida;
    logic          pronta;
    logic          aceita;
    logic          consome;

    assign pronta  = (estado == ACUMULA) || bus.saida_pronta;
    assign aceita  = bus.entrada_valida && pronta;
    assign consome = valida && bus.saida_pronta;

    // A consume in the same cycle as an accept starts the next word from zero,
    // so the incoming field lands alone at the entry position.
    always_comb begin
        campo_ext = W'(bus.entrada);
        base      = consome ? '0 : acc;
        if (ORDEM == 0) begin
            nova = (base << CAMPO) | campo_ext;
        end else begin
            nova = (base >> CAMPO) | (campo_ext << (W - CAMPO));
        end
        cont_nova = consome ? CW'(1) : cont + CW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= ACUMULA;
            acc    <= '0;
            cont   <= '0;
            valida <= 1'b0;
        end else if (limpa) begin
            estado <= ACUMULA;
            acc    <= '0;
            cont   <= '0;
            valida <= 1'b0;
        end else if (aceita) begin
            acc  <= nova;
            cont <= cont_nova;
            if (cont_nova == CW'(NCAMPOS)) begin
                estado <= CHEIO;
                valida <= 1'b1;
            end else begin
                estado <= ACUMULA;
                valida <= 1'b0;
            end
        end else if (consome) begin
            estado <= ACUMULA;
            acc    <= '0;
            cont   <= '0;
            valida <= 1'b0;
        end
    end

    assign bus.entrada_pronta = pronta;
    assign bus.Saida          = acc;
    assign bus.saida_valida   = valida;
    assign contagem           = cont;
endmodule

// File: tb/tb_concatena_campos.sv
// tb/tb_concatena_campos.sv - scoreboard bench for concatena_campos across orderings and sizes
module tb_concatena_campos;
    logic clock = 1'b0;
    logic reset;
    logic limpa;
    logic limpa_c;
    logic limpa_d;
    logic [1:0] cont_a;
    logic [1:0] cont_b;
    logic [1:0] cont_c;
    logic [0:0] cont_d;

    int checks = 0;
    int errors = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] qc[$];
    logic [15:0] qd[$];
    logic [15:0] ea, eb, ec, ed;

    always #5 clock = ~clock;

    concatena_campos_if #(.CAMPO(4), .NCAMPOS(3)) ia ();
    concatena_campos_if #(.CAMPO(4), .NCAMPOS(3)) ib ();
    concatena_campos_if #(.CAMPO(8), .NCAMPOS(2)) ic ();
    concatena_campos_if #(.CAMPO(4), .NCAMPOS(1)) id ();

    assign ib.entrada_valida = ia.entrada_valida;
    assign ib.entrada        = ia.entrada;
    assign ib.saida_pronta   = ia.saida_pronta;

    concatena_campos #(.CAMPO(4), .NCAMPOS(3), .ORDEM(0)) dut_a (
        .clock(clock), .reset(reset), .limpa(limpa), .bus(ia), .contagem(cont_a));
    concatena_campos #(.CAMPO(4), .NCAMPOS(3), .ORDEM(1)) dut_b (
        .clock(clock), .reset(reset), .limpa(limpa), .bus(ib), .contagem(cont_b));
    concatena_campos #(.CAMPO(8), .NCAMPOS(2), .ORDEM(0)) dut_c (
        .clock(clock), .reset(reset), .limpa(limpa_c), .bus(ic), .contagem(cont_c));
    concatena_campos #(.CAMPO(4), .NCAMPOS(1), .ORDEM(0)) dut_d (
        .clock(clock), .reset(reset), .limpa(limpa_d), .bus(id), .contagem(cont_d));

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    task automatic word(input string nome, input logic [15:0] got, input bit tem, input logic [15:0] exp);
        checks++;
        if (!tem) begin
            errors++;
            $display("FAIL %s: got word %0h expected no word", nome, got);
        end else if (got !== exp) begin
            errors++;
            $display("FAIL %s: got word %0h expected %0h", nome, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitors: every consume is compared with the next queued word
    always @(negedge clock) begin
        if (ia.saida_valida && ia.saida_pronta) begin
            if (qa.size() != 0) begin ea = qa.pop_front(); word("word_a", 16'(ia.Saida), 1'b1, ea); end
            else word("word_a", 16'(ia.Saida), 1'b0, 16'h0);
        end
        if (ib.saida_valida && ib.saida_pronta) begin
            if (qb.size() != 0) begin eb = qb.pop_front(); word("word_b", 16'(ib.Saida), 1'b1, eb); end
            else word("word_b", 16'(ib.Saida), 1'b0, 16'h0);
        end
        if (ic.saida_valida && ic.saida_pronta) begin
            if (qc.size() != 0) begin ec = qc.pop_front(); word("word_c", ic.Saida, 1'b1, ec); end
            else word("word_c", ic.Saida, 1'b0, 16'h0);
        end
        if (id.saida_valida && id.saida_pronta) begin
            if (qd.size() != 0) begin ed = qd.pop_front(); word("word_d", 16'(id.Saida), 1'b1, ed); end
            else word("word_d", 16'(id.Saida), 1'b0, 16'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        limpa = 1'b0; limpa_c = 1'b0; limpa_d = 1'b0;
        ia.entrada_valida = 1'b0; ia.entrada = '0; ia.saida_pronta = 1'b0;
        ic.entrada_valida = 1'b0; ic.entrada = '0; ic.saida_pronta = 1'b0;
        id.entrada_valida = 1'b0; id.entrada = '0; id.saida_pronta = 1'b0;
        #1;
        check("pronta_in_reset", 32'(ia.entrada_pronta), 32'h1);
        step(); step();
        reset = 1'b0;
        step();
        check("reset_saida", 32'(ia.Saida), 32'h000);
        check("reset_valida", 32'(ia.saida_valida), 32'h0);
        check("reset_contagem", 32'(cont_a), 32'h0);
        check("reset_pronta", 32'(ia.entrada_pronta), 32'h1);

        // Fill ABC with the consumer stalled
        ia.entrada_valida = 1'b1;
        ia.entrada = 4'hA; step();
        check("fill_cont1", 32'(cont_a), 32'h1);
        check("fill_part1", 32'(ia.Saida), 32'h00A);
        ia.entrada = 4'hB; step();
        check("fill_cont2", 32'(cont_a), 32'h2);
        check("fill_valida_early", 32'(ia.saida_valida), 32'h0);
        qa.push_back(16'hABC); qb.push_back(16'hCBA);
        ia.entrada = 4'hC; step();
        check("fill_cont3", 32'(cont_a), 32'h3);
        check("fill_saida_a", 32'(ia.Saida), 32'hABC);
        check("fill_valida_a", 32'(ia.saida_valida), 32'h1);
        check("fill_saida_b", 32'(ib.Saida), 32'hCBA);
        check("fill_valida_b", 32'(ib.saida_valida), 32'h1);
        ia.entrada = 4'hD;
        check("stall_pronta", 32'(ia.entrada_pronta), 32'h0);
        step();
        check("stall_saida", 32'(ia.Saida), 32'hABC);
        check("stall_cont", 32'(cont_a), 32'h3);
        ia.entrada_valida = 1'b0; ia.saida_pronta = 1'b1; step();
        check("consume_saida", 32'(ia.Saida), 32'h000);
        check("consume_cont", 32'(cont_a), 32'h0);
        check("consume_valida", 32'(ia.saida_valida), 32'h0);

        // Back-to-back stream 1..6 with the consumer always ready
        ia.entrada_valida = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            ia.entrada = 4'(i);
            if (i == 3) begin qa.push_back(16'h123); qb.push_back(16'h321); end
            if (i == 6) begin qa.push_back(16'h456); qb.push_back(16'h654); end
            check("stream_pronta", 32'(ia.entrada_pronta), 32'h1);
            step();
            if (i == 4) begin
                check("b2b_saida_a", 32'(ia.Saida), 32'h004);
                check("b2b_saida_b", 32'(ib.Saida), 32'h400);
                check("b2b_cont", 32'(cont_a), 32'h1);
            end
        end
        check("b2b_last_saida", 32'(ia.Saida), 32'h456);
        ia.entrada_valida = 1'b0; step();
        ia.saida_pronta = 1'b0;

        // limpa mid-word drops the simultaneous field
        ia.entrada_valida = 1'b1;
        ia.entrada = 4'h7; step();
        ia.entrada = 4'h8; step();
        ia.entrada = 4'h9; limpa = 1'b1; step();
        check("limpa_saida", 32'(ia.Saida), 32'h000);
        check("limpa_cont", 32'(cont_a), 32'h0);
        limpa = 1'b0;

        // Asynchronous reset between clock edges
        ia.entrada = 4'h7; step();
        ia.entrada = 4'h8; step();
        ia.entrada_valida = 1'b0;
        check("pre_reset_cont", 32'(cont_a), 32'h2);
        check("pre_reset_saida", 32'(ia.Saida), 32'h078);
        #2 reset = 1'b1;
        #1;
        check("async_saida", 32'(ia.Saida), 32'h000);
        check("async_cont", 32'(cont_a), 32'h0);
        check("async_valida", 32'(ia.saida_valida), 32'h0);
        check("async_pronta", 32'(ia.entrada_pronta), 32'h1);
        step();
        reset = 1'b0;
        step();

        // CAMPO=8, NCAMPOS=2
        ic.entrada_valida = 1'b1;
        ic.entrada = 8'h12; step();
        qc.push_back(16'h1234);
        ic.entrada = 8'h34; step();
        ic.entrada_valida = 1'b0;
        check("wide_saida", 32'(ic.Saida), 32'h1234);
        check("wide_valida", 32'(ic.saida_valida), 32'h1);
        check("wide_cont", 32'(cont_c), 32'h2);
        ic.saida_pronta = 1'b1; step();
        ic.saida_pronta = 1'b0;

        // NCAMPOS=1: one valid word per cycle
        id.saida_pronta = 1'b1;
        id.entrada_valida = 1'b1;
        for (int i = 5; i <= 7; i++) begin
            id.entrada = 4'(i);
            qd.push_back(16'(i));
            check("single_pronta", 32'(id.entrada_pronta), 32'h1);
            step();
            check("single_valida", 32'(id.saida_valida), 32'h1);
            check("single_saida", 32'(id.Saida), 32'(i));
        end
        id.entrada_valida = 1'b0; step();
        id.saida_pronta = 1'b0;
        check("single_drained", 32'(id.saida_valida), 32'h0);

        step(); step();
        check("qa_empty", 32'(qa.size()), 32'h0);
        check("qb_empty", 32'(qb.size()), 32'h0);
        check("qc_empty", 32'(qc.size()), 32'h0);
        check("qd_empty", 32'(qd.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/concatena_campos.md
# concatena_campos

Parametrised field-concatenation register that starts from an all-zero word and packs NCAMPOS incoming fields of CAMPO bits each into one Saida word. It is the sequential successor to the fixed 12-bit zero-constant generator. With the default parameters it produces the same 12-bit zero start value, then fills the word field by field under a valid/ready handshake. It sits between the pixel/field producer and any consumer that needs a full packed word, such as the memory write path.

## Interface

Parameters:
- CAMPO, default 4: width of one input field in bits (≥1).
- NCAMPOS, default 3: fields per output word (≥1). The word width is W = CAMPO*NCAMPOS, which is 12 by default.
- ORDEM, default 0. 0 = first field ends in the MSBs: shift left, new field enters the LSBs. 1 = first field ends in the LSBs: shift right, new field enters the MSBs.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- limpa, input, 1: synchronous clear; discards the partial or full word.
- entrada_valida, input, 1: entrada holds a valid field.
- entrada, input, CAMPO: field data.
- entrada_pronta, output, 1: block accepts a field this cycle.
- Saida, output, W: accumulator contents; a complete word when saida_valida=1.
- saida_valida, output, 1: Saida holds a complete word.
- saida_pronta, input, 1: consumer takes the word this cycle.
- contagem, output, $clog2(NCAMPOS+1): number of fields accepted into the current word.

## Operation

- **States.**
  - ACUMULA: contagem < NCAMPOS, saida_valida=0.
  - CHEIO: contagem = NCAMPOS, saida_valida=1.
- **Acceptance.** entrada_pronta = (state==ACUMULA) or saida_pronta. This is combinational from state and saida_pronta; there is no path from entrada_valida.
- **Accept.** An accept occurs when entrada_valida and entrada_pronta are both 1.
  - ORDEM=0: Saida <= {Saida[W-CAMPO-1:0], entrada}.
  - ORDEM=1: Saida <= {entrada, Saida[W-1:CAMPO]}.
  - contagem increments.
- **ACUMULA → CHEIO.** Taken on the accept that brings contagem to NCAMPOS.
- **CHEIO.** Saida and contagem hold while saida_pronta=0. Input is stalled (entrada_pronta=0).
- **Consume.** A consume is saida_valida and saida_pronta both 1.
  - Without a simultaneous accept: Saida <= 0, contagem <= 0, state goes to ACUMULA.
  - With a simultaneous accept: the new field becomes field 1 of the next word. Saida <= zero word with that field inserted at the entry position (LSBs for ORDEM=0, MSBs for ORDEM=1), contagem <= 1, state goes to ACUMULA. If NCAMPOS=1, the state goes to CHEIO instead and stays valid; this is back-to-back throughput.
- **limpa.** Priority is reset > limpa > consume/accept. On limpa: Saida <= 0, contagem <= 0, state goes to ACUMULA. Any field or consume in the same cycle is ignored.
- **Reset.** Asserting reset, including mid-word or while in CHEIO, immediately forces Saida=0, contagem=0, saida_valida=0 and state ACUMULA. Because entrada_pronta is combinational, it reads 1 during reset.
- **Partial contents.** Saida is visible while in ACUMULA. Downstream must qualify it with saida_valida. Unfilled positions read 0.
- **Arithmetic.** No arithmetic beyond the shift; contagem never exceeds NCAMPOS.

## Timing

- All outputs except entrada_pronta are registered.
- **Latency.** saida_valida rises on the clock edge that captures the NCAMPOS-th field, so it is visible the following cycle.
- **Minimum fill time.** NCAMPOS cycles per word with entrada_valida held at 1.
- **Sustained throughput.** With saida_pronta held at 1, the block sustains one field per cycle with no bubble at word boundaries.
- **Holding rule.** Once asserted, saida_valida stays 1 and Saida stays stable until a consume, limpa or reset.
- **Reset values.** Saida=0, saida_valida=0, contagem=0, entrada_pronta=1.

## Test plan

All scenarios use defaults unless stated.

1. **Reset value.** Assert reset for 2 cycles, then release → Saida=12'h000, saida_valida=0, contagem=0, entrada_pronta=1.
2. **ORDEM=0 fill.** Fields 4'hA, 4'hB, 4'hC on consecutive cycles with saida_pronta=0 → contagem 1, 2, 3; Saida=12'hABC with saida_valida=1 one cycle after C. A 4'hD held valid is stalled (entrada_pronta=0) and Saida stays 12'hABC.
3. **ORDEM=1 fill.** Same stimulus with ORDEM=1 → Saida=12'hCBA with saida_valida=1.
4. **Back-to-back.** Stream 4'h1 through 4'h6 continuously with saida_pronta=1 → words 12'h123 then 12'h456. On the cycle 12'h123 is consumed while 4'h4 is accepted, Saida goes to 12'h004 with contagem=1. No stall cycles occur.
5. **limpa and reset mid-word.**
   - After 4'h7, 4'h8, assert limpa together with entrada_valida=1 and entrada=4'h9 → Saida=0, contagem=0, and 4'h9 is dropped.
   - Repeat, but assert reset asynchronously between clock edges → outputs go to the reset values immediately.
6. **Generic sizing.** CAMPO=8, NCAMPOS=2, ORDEM=0: fields 8'h12, 8'h34 → Saida=16'h1234, saida_valida=1. NCAMPOS=1: with saida_pronta=1, every accepted field appears as a valid word each cycle.
